button_event: RTL and testbench

Converts the single-bit, already-debounced button level produced by the `debouncer` stage into discrete, one-clock-wide events for downstream control logic: press, release, long-press and auto-repeat. It also maintains a press counter and a held flag. It sits directly downstream of `debouncer`; its `button_in` is wired to the debouncer's `button_out`, which is synchronous to the same clock.

---
 rtl/button_event.sv | 125 ++++++++++++
 tb/tb_button_event.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Turns the debounced button level into one-cycle press / release / long-press /
// auto-repeat events, plus a wrapping press counter and a held flag.
module button_event #(
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 4,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   button_in,
    output logic                   press,
    output logic                   release_event,
    output logic                   long_press,
    output logic                   repeat_event,
    output logic                   held,
    output logic [COUNT_WIDTH-1:0] press_count
);

    localparam int MAX_HOLD = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW       = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        DISARMED,
        IDLE,
        PRESSED,
        LONG
    } state_t;

    state_t                 state_reg, state_next;
    logic [HW-1:0]          hold_reg, hold_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic                   press_reg, press_next;
    logic                   release_reg, release_next;
    logic                   long_reg, long_next;
    logic                   repeat_reg, repeat_next;
    logic                   held_reg, held_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= DISARMED;
            hold_reg    <= '0;
            count_reg   <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
            repeat_reg  <= 1'b0;
            held_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hold_reg    <= hold_next;
            count_reg   <= count_next;
            press_reg   <= press_next;
            release_reg <= release_next;
            long_reg    <= long_next;
            repeat_reg  <= repeat_next;
            held_reg    <= held_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        count_next   = count_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;

        case (state_reg)
            // A button held through reset must be seen low once before it can press.
            DISARMED: begin
                if (!button_in) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (button_in) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                    count_next = count_reg + COUNT_WIDTH'(1);
                    hold_next  = HW'(1);
                end
            end
            PRESSED: begin
                if (!button_in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    hold_next    = '0;
                end else if (hold_reg == HW'(LONG_CYCLES - 1)) begin
                    state_next = LONG;
                    long_next  = 1'b1;
                    hold_next  = HW'(1);
                end else begin
                    hold_next = hold_reg + HW'(1);
                end
            end
            LONG: begin
                if (!button_in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    hold_next    = '0;
                end else if (hold_reg == HW'(REPEAT_CYCLES)) begin
                    repeat_next = 1'b1;
                    hold_next   = HW'(1);
                end else begin
                    hold_next = hold_reg + HW'(1);
                end
            end
            default: begin
                state_next = DISARMED;
                hold_next  = '0;
            end
        endcase

        held_next = (state_next == PRESSED) || (state_next == LONG);
    end

    assign press         = press_reg;
    assign release_event = release_reg;
    assign long_press    = long_reg;
    assign repeat_event  = repeat_reg;
    assign held          = held_reg;
    assign press_count   = count_reg;

endmodule

// File: tb/tb_button_event.sv
// Directed and randomized stimulus for button_event, checked every cycle against a
// run-length model of the button hold.
module tb_button_event;

    localparam int LONG_C   = 16;
    localparam int REPEAT_C = 4;
    localparam int CW       = 8;

    logic          clock;
    logic          reset;
    logic          button_in;
    logic          press;
    logic          release_event;
    logic          long_press;
    logic          repeat_event;
    logic          held;
    logic [CW-1:0] press_count;

    button_event #(
        .LONG_CYCLES  (LONG_C),
        .REPEAT_CYCLES(REPEAT_C),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .button_in    (button_in),
        .press        (press),
        .release_event(release_event),
        .long_press   (long_press),
        .repeat_event (repeat_event),
        .held         (held),
        .press_count  (press_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Model: armed once a low sample follows reset; run = consecutive high samples
    // since the accepted press (0 when not held).
    bit            m_armed = 1'b0;
    int            m_run   = 0;
    logic [CW-1:0] m_count = '0;
    logic          e_press, e_rel, e_long, e_rep, e_held;

    task automatic step(input logic b, input logic r);
        @(negedge clock);
        button_in = b;
        reset     = r;
        @(posedge clock);
        cycle++;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (r) begin
            m_armed = 1'b0;
            m_run   = 0;
            m_count = '0;
        end else if (!b) begin
            e_rel   = (m_run > 0);
            m_run   = 0;
            m_armed = 1'b1;
        end else if (m_run > 0) begin
            m_run++;
            e_long = (m_run == LONG_C);
            e_rep  = (m_run > LONG_C) && (((m_run - LONG_C) % REPEAT_C) == 0);
        end else if (m_armed) begin
            e_press = 1'b1;
            m_run   = 1;
            m_count = m_count + 1'b1;
        end
        e_held = (m_run > 0);
        #1;
        tests += 6;
        assert (press === e_press) else begin
            fails++;
            $error("FAIL press: got %b expected %b at cycle %0d", press, e_press, cycle);
        end
        assert (release_event === e_rel) else begin
            fails++;
            $error("FAIL release: got %b expected %b at cycle %0d", release_event, e_rel, cycle);
        end
        assert (long_press === e_long) else begin
            fails++;
            $error("FAIL long_press: got %b expected %b at cycle %0d", long_press, e_long, cycle);
        end
        assert (repeat_event === e_rep) else begin
            fails++;
            $error("FAIL repeat: got %b expected %b at cycle %0d", repeat_event, e_rep, cycle);
        end
        assert (held === e_held) else begin
            fails++;
            $error("FAIL held: got %b expected %b at cycle %0d", held, e_held, cycle);
        end
        assert (press_count === m_count) else begin
            fails++;
            $error("FAIL press_count: got %0d expected %0d at cycle %0d", press_count, m_count, cycle);
        end
    endtask

    task automatic hold_high(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    initial begin
        button_in = 1'b0;
        reset     = 1'b1;

        // 1: short press after reset
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        hold_high(5);
        step(1'b0, 1'b0);
        tests++;
        assert (press_count === 8'd1) else begin
            fails++;
            $error("FAIL short_count: got %0d expected 1", press_count);
        end
        $display("[TB] short press done, press_count=%0d", press_count);

        // 2: long hold with repeats
        step(1'b0, 1'b0);
        hold_high(30);
        step(1'b0, 1'b0);
        $display("[TB] 30-cycle hold done, press_count=%0d", press_count);

        // 3: exactly LONG and LONG-1 high samples
        step(1'b0, 1'b0);
        hold_high(16);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        hold_high(15);
        step(1'b0, 1'b0);
        $display("[TB] boundary holds done, press_count=%0d", press_count);

        // 4: reset while in LONG, button stays high
        step(1'b0, 1'b0);
        hold_high(20);
        step(1'b1, 1'b1);
        hold_high(10);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        tests++;
        assert (press === 1'b1 && press_count === 8'd1) else begin
            fails++;
            $error("FAIL repress_after_reset: got press=%b count=%0d expected press=1 count=1",
                   press, press_count);
        end
        step(1'b0, 1'b0);
        $display("[TB] reset in LONG done, press_count=%0d", press_count);

        // 5: counter wrap
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int p = 0; p < 256; p++) begin
            hold_high(2);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end
        tests++;
        assert (press_count === 8'd0) else begin
            fails++;
            $error("FAIL wrap_count: got %0d expected 0", press_count);
        end
        hold_high(2);
        step(1'b0, 1'b0);
        tests++;
        assert (press_count === 8'd1) else begin
            fails++;
            $error("FAIL wrap_plus_one: got %0d expected 1", press_count);
        end
        $display("[TB] 257 presses done, press_count=%0d", press_count);

        // 6: release immediately followed by a new press
        step(1'b0, 1'b0);
        hold_high(3);
        step(1'b0, 1'b0);
        tests++;
        assert (release_event === 1'b1) else begin
            fails++;
            $error("FAIL bounce_release: got %b expected 1", release_event);
        end
        step(1'b1, 1'b0);
        tests++;
        assert (press === 1'b1 && press_count === 8'd3) else begin
            fails++;
            $error("FAIL bounce_press: got press=%b count=%0d expected press=1 count=3",
                   press, press_count);
        end
        step(1'b0, 1'b0);
        $display("[TB] back-to-back release/press done, press_count=%0d", press_count);

        // Random bursts with occasional mid-hold reset
        for (int k = 0; k < 40; k++) begin
            int len;
            int gap;
            int rst_at;
            len    = $urandom_range(1, 40);
            gap    = $urandom_range(1, 4);
            rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int i = 0; i < len; i++) step(1'b1, (i == rst_at) ? 1'b1 : 1'b0);
            for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
            $display("[TB] random burst %0d: high=%0d low=%0d reset_at=%0d press_count=%0d",
                     k, len, gap, rst_at, press_count);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
